// File: rtl/rr_select_block_pkg.sv
// Shared select-tree definitions: default sizing, width helpers and the
// priority-mode encoding used by rr_select_block and its scan sub-module.
package rr_select_block_pkg;

   localparam int unsigned DEF_SIZE_SELECT_BLOCK = 16;
   localparam int unsigned DEF_NUM_GRANTS        = 2;

   typedef enum logic {
      PRIO_FIXED = 1'b0,
      PRIO_RR    = 1'b1
   } prio_mode_e;

   function automatic int unsigned ptr_width(input int unsigned size);
      return (size > 1) ? $clog2(size) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   localparam int unsigned DEF_PTR_W = ptr_width(DEF_SIZE_SELECT_BLOCK);
   localparam int unsigned DEF_CNT_W = cnt_width(DEF_NUM_GRANTS);

endpackage

// File: rtl/rr_select_block_rr_multi_pencoder.sv
// Circular multi-grant priority encoder: marks the first NUM_GRANTS set
// request bits scanning upward from start_i, and reports the last one marked.
module rr_multi_pencoder
   import rr_select_block_pkg::*;
#(
   parameter int unsigned SIZE       = DEF_SIZE_SELECT_BLOCK,
   parameter int unsigned NUM_GRANTS = DEF_NUM_GRANTS,
   parameter int unsigned PTR_W      = DEF_PTR_W
) (
   input  logic [SIZE-1:0]  req_i,
   input  logic [PTR_W-1:0] start_i,
   output logic [SIZE-1:0]  sel_o,
   output logic [PTR_W-1:0] last_o
);

   logic [SIZE-1:0]  rot;
   logic [SIZE-1:0]  rot_sel;
   logic [PTR_W-1:0] rot_last;
   int unsigned      taken;

   // Rotate so the search start lands on bit 0; index math wraps at SIZE.
   always_comb begin
      rot = '0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         rot[i] = req_i[PTR_W'(i) + start_i];
      end
   end

   always_comb begin
      rot_sel  = '0;
      rot_last = '0;
      taken    = 0;
      for (int unsigned i = 0; i < SIZE; i++) begin
         if (rot[i] && (taken < NUM_GRANTS)) begin
            rot_sel[i] = 1'b1;
            rot_last   = PTR_W'(i);
            taken      = taken + 1;
         end
      end
   end

   // Unrotate by reading back through the inverse offset, so every output
   // bit has a single fixed driver.
   always_comb begin
      sel_o = '0;
      for (int unsigned j = 0; j < SIZE; j++) begin
         sel_o[j] = rot_sel[PTR_W'(j) - start_i];
      end
   end

   assign last_o = rot_last + start_i;

endmodule

// File: rtl/rr_select_block.sv
// One node of a select tree: round-robin or fixed-priority multi-grant
// selection over req_i, gated by the grant returned from the next stage.
module rr_select_block
   import rr_select_block_pkg::*;
#(
   parameter  int unsigned SIZE_SELECT_BLOCK = DEF_SIZE_SELECT_BLOCK,
   parameter  int unsigned NUM_GRANTS        = DEF_NUM_GRANTS,
   localparam int unsigned PTR_W             = ptr_width(SIZE_SELECT_BLOCK),
   localparam int unsigned CNT_W             = cnt_width(NUM_GRANTS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [SIZE_SELECT_BLOCK-1:0] req_i,
   input  logic                         grant_i,
   input  logic                         rr_mode_i,
   output logic [SIZE_SELECT_BLOCK-1:0] grant_o,
   output logic                         req_o,
   output logic [CNT_W-1:0]             grant_cnt_o,
   output logic [PTR_W-1:0]             ptr_o
);

   prio_mode_e                   mode;
   logic [PTR_W-1:0]             ptr_q;
   logic [PTR_W-1:0]             start;
   logic [PTR_W-1:0]             last_idx;
   logic [SIZE_SELECT_BLOCK-1:0] pick;
   logic [SIZE_SELECT_BLOCK-1:0] grant;
   logic [CNT_W-1:0]             cnt;

   assign mode  = prio_mode_e'(rr_mode_i);
   assign start = (mode == PRIO_RR) ? ptr_q : '0;

   rr_multi_pencoder #(
      .SIZE       (SIZE_SELECT_BLOCK),
      .NUM_GRANTS (NUM_GRANTS),
      .PTR_W      (PTR_W)
   ) u_penc (
      .req_i   (req_i),
      .start_i (start),
      .sel_o   (pick),
      .last_o  (last_idx)
   );

   // Reset gates the grant combinationally so nothing leaks out while held.
   assign grant = (grant_i && reset) ? pick : '0;

   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < SIZE_SELECT_BLOCK; i++) begin
         cnt = cnt + CNT_W'(grant[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
      end else if ((mode == PRIO_RR) && (|grant)) begin
         ptr_q <= last_idx + PTR_W'(1);
      end
   end

   assign grant_o     = grant;
   assign grant_cnt_o = cnt;
   assign req_o       = |req_i;
   assign ptr_o       = ptr_q;

endmodule
